// File: rtl/spi_target_pkg.sv
// spi_target_pkg: controller states, word lengths and word formatting shared by the SPI target.
package spi_target_pkg;
    typedef enum logic [1:0] {IDLE, ACTIVE, LOCKOUT} state_e;
    localparam logic [4:0] WORD_8 = 5'd8;
    localparam logic [4:0] WORD_16 = 5'd16;
    function automatic logic [15:0] fit_word(input logic w16, input logic [15:0] w);
        return w16 ? w : {8'h00, w[7:0]};
    endfunction
endpackage

// File: rtl/spi_target_sync_edge.sv
// spi_target_sync_edge: multi-stage input synchronizer with registered rise/fall pulses.
module spi_target_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic raw_clk,
    input  logic reset,
    input  logic d_in,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic prev_q, prev_d, rise_q, rise_d, fall_q, fall_d;
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
        prev_d = sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
        fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
    end
    always_ff @(posedge raw_clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end
    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = rise_q;
    assign fall  = fall_q;
endmodule

// File: rtl/spi_target.sv
// spi_target: mode-0 MSB-first SPI responder with single-word tx buffer and rx holding register.
module spi_target import spi_target_pkg::*; #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        raw_clk,
    input  logic        reset,
    input  logic        width_16,
    input  logic [15:0] tx_data,
    input  logic        tx_load,
    output logic        tx_empty,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    input  logic        rx_ack,
    output logic        overrun,
    input  logic        overrun_clr,
    output logic        busy,
    input  logic        spi_cs_n,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe
);
    state_e state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic width_q, width_d, reload_q, reload_d, tx_empty_q, tx_empty_d;
    logic rx_valid_q, rx_valid_d, overrun_q, overrun_d;
    logic [15:0] shift_tx_q, shift_tx_d, shift_rx_q, shift_rx_d;
    logic [15:0] tx_buf_q, tx_buf_d, rx_data_q, rx_data_d, tx_next, rx_next;
    logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
    logic cs_s, cs_rise, cs_fall, sclk_s, sclk_rise, sclk_fall, consume;

    spi_target_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
        .raw_clk(raw_clk), .reset(reset), .d_in(spi_cs_n),
        .level(cs_s), .rise(cs_rise), .fall(cs_fall)
    );
    spi_target_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
        .raw_clk(raw_clk), .reset(reset), .d_in(spi_sclk),
        .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        width_d    = width_q;
        reload_d   = reload_q;
        shift_tx_d = shift_tx_q;
        shift_rx_d = shift_rx_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q & ~rx_ack;
        overrun_d  = overrun_q & ~overrun_clr;
        mosi_d     = {mosi_q[SYNC_STAGES-2:0], spi_mosi};
        tx_next    = tx_empty_q ? 16'h0000 : tx_buf_q;
        rx_next    = {shift_rx_q[14:0], mosi_q[SYNC_STAGES-1]};
        consume    = 1'b0;
        case (state_q)
            // Synchronizer reset values are not trusted: require an idle bus for a full flush.
            LOCKOUT: begin
                cnt_d = (cs_s && !sclk_s) ? cnt_q + 5'd1 : 5'd0;
                if (cs_s && !sclk_s && cnt_q >= 5'(SYNC_STAGES)) begin
                    state_d = IDLE;
                    cnt_d   = 5'd0;
                end
            end
            IDLE: if (cs_fall && !cs_s) begin
                state_d    = ACTIVE;
                width_d    = width_16;
                shift_tx_d = tx_next;
                consume    = 1'b1;
                cnt_d      = 5'd0;
                reload_d   = 1'b0;
            end
            ACTIVE: if (cs_s || cs_rise) begin
                state_d  = IDLE;
                cnt_d    = 5'd0;
                reload_d = 1'b0;
            end else if (sclk_rise) begin
                shift_rx_d = rx_next;
                cnt_d      = cnt_q + 5'd1;
                if (cnt_d == (width_q ? WORD_16 : WORD_8)) begin
                    cnt_d    = 5'd0;
                    reload_d = 1'b1;
                    if (!rx_valid_q || rx_ack) begin
                        rx_data_d  = fit_word(width_q, rx_next);
                        rx_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end else if (sclk_fall) begin
                shift_tx_d = reload_q ? tx_next : shift_tx_q << 1;
                consume    = reload_q;
                reload_d   = 1'b0;
            end
            default: state_d = LOCKOUT;
        endcase
        // A load coinciding with consumption wins: consumer already took the old word.
        tx_buf_d   = tx_load ? tx_data : tx_buf_q;
        tx_empty_d = tx_load ? 1'b0 : (consume | tx_empty_q);
    end

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            state_q    <= LOCKOUT;
            cnt_q      <= 5'd0;
            width_q    <= 1'b0;
            reload_q   <= 1'b0;
            shift_tx_q <= 16'h0000;
            shift_rx_q <= 16'h0000;
            tx_buf_q   <= 16'h0000;
            tx_empty_q <= 1'b1;
            rx_data_q  <= 16'h0000;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            mosi_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            width_q    <= width_d;
            reload_q   <= reload_d;
            shift_tx_q <= shift_tx_d;
            shift_rx_q <= shift_rx_d;
            tx_buf_q   <= tx_buf_d;
            tx_empty_q <= tx_empty_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            mosi_q     <= mosi_d;
        end
    end

    assign busy        = (state_q == ACTIVE) && !cs_s;
    assign spi_miso_oe = busy;
    assign spi_miso    = busy && (width_q ? shift_tx_q[15] : shift_tx_q[7]);
    assign tx_empty    = tx_empty_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign overrun     = overrun_q;
endmodule
